gate_truth_table_sweeper: RTL and testbench

//  Parametrised, self-sequencing gate exerciser for the logic_gates library.
//  On a start pulse it drives every N-bit input vector (0 .. 2**N-1) in

---
 rtl/gate_truth_table_sweeper.sv | 102 ++++++++++
 tb/tb_gate_truth_table_sweeper.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_sweeper.sv
// Self-sequencing gate exerciser: sweeps every N-bit vector, holds each for
// HOLD cycles, evaluates the selected gate and accumulates the truth table.
module gate_truth_table_sweeper #(
  parameter int N    = 2,
  parameter int HOLD = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          mode,
  output logic [N-1:0]        a,
  output logic                y,
  output logic                valid,
  output logic [(1<<N)-1:0]   truth_table,
  output logic                busy,
  output logic                done
);

  localparam int TT_W  = 1 << N;
  localparam int CNT_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
  localparam logic [N-1:0]     VEC_LAST = N'(TT_W - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [2:0]       mode_q;
  logic [N-1:0]     vec;
  logic [CNT_W-1:0] cnt;
  logic             last_cnt, last_vec, accept, gate_bit;

  function automatic logic gate_eval(input logic [2:0] m, input logic [N-1:0] v);
    case (m)
      3'd0:    gate_eval = &v;
      3'd1:    gate_eval = |v;
      3'd2:    gate_eval = ~&v;
      3'd3:    gate_eval = ~|v;
      3'd4:    gate_eval = ^v;
      3'd5:    gate_eval = ~^v;
      3'd6:    gate_eval = v[0];
      default: gate_eval = ~v[0];
    endcase
  endfunction

  assign last_cnt = (cnt == CNT_LAST);
  assign last_vec = (vec == VEC_LAST);
  assign gate_bit = gate_eval(mode_q, vec);
  assign a        = vec;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_cnt && last_vec) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == RUN);
    accept = (state_q == IDLE) && start;
  end

  // Sweep datapath: evaluation happens on the final cycle of each hold window
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= '0;
      vec         <= '0;
      cnt         <= '0;
      y           <= 1'b0;
      valid       <= 1'b0;
      truth_table <= '0;
      done        <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        mode_q      <= mode;
        vec         <= '0;
        cnt         <= '0;
        truth_table <= '0;
        done        <= 1'b0;
      end else if (state_q == RUN) begin
        if (last_cnt) begin
          y                <= gate_bit;
          truth_table[vec] <= gate_bit;
          valid            <= 1'b1;
          cnt              <= '0;
          if (last_vec) done <= 1'b1;
          else          vec  <= vec + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_table_sweeper.sv
// Bench for gate_truth_table_sweeper: three parameter sets, each checked every
// cycle against an elapsed-time model plus literal truth-table expectations.
module tb_gate_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam int NCFG = 3;
  localparam int CFG_N   [NCFG] = '{2, 3, 2};
  localparam int CFG_HOLD[NCFG] = '{10, 2, 1};
  localparam int CFG_MODE[NCFG] = '{3, 4, 7};
  localparam int CFG_TT  [NCFG] = '{32'h1, 32'h96, 32'h5};

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Gate value from the number of ones in the vector
  function automatic bit model_f(input int n, input int m, input int v);
    int ones;
    ones = $countones(v);
    case (m)
      0:       model_f = (ones == n);
      1:       model_f = (ones != 0);
      2:       model_f = (ones != n);
      3:       model_f = (ones == 0);
      4:       model_f = (ones % 2) == 1;
      5:       model_f = (ones % 2) == 0;
      6:       model_f = (v % 2) == 1;
      default: model_f = (v % 2) == 0;
    endcase
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int GN = CFG_N[g];
    localparam int GH = CFG_HOLD[g];
    localparam int TW = 1 << GN;

    logic          rst, start;
    logic [2:0]    mode;
    logic [GN-1:0] a;
    logic          y, valid, busy, done;
    logic [TW-1:0] tt;
    bit            fin = 1'b0;
    bit            armed = 1'b0;

    bit     m_run, e_y, e_valid, e_busy, e_done;
    int     m_j, m_mode, e_a;
    longint e_tt;

    gate_truth_table_sweeper #(.N(GN), .HOLD(GH)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .y(y),
      .valid(valid), .truth_table(tt), .busy(busy), .done(done)
    );

    // Model: j edges after acceptance, j/HOLD vectors have been evaluated
    initial forever begin
      @(posedge clk);
      if (rst) begin
        armed = 1'b1; m_run = 1'b0; m_j = 0; m_mode = 0; e_a = 0;
        e_y = 1'b0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_tt = 0;
      end else if (!m_run) begin
        e_valid = 1'b0;
        if (start) begin
          m_run = 1'b1; m_j = 0; m_mode = int'(mode); e_tt = 0;
          e_done = 1'b0; e_a = 0; e_busy = 1'b1;
        end
      end else begin
        int e;
        m_j++;
        e = m_j / GH;
        e_valid = (m_j % GH) == 0;
        if (e_valid) begin
          e_y = model_f(GN, m_mode, e - 1);
          e_tt[e-1] = e_y;
        end
        e_a = (e < TW) ? e : TW - 1;
        if (m_j == TW * GH) begin
          m_run = 1'b0; e_busy = 1'b0; e_done = 1'b1;
        end
      end
    end

    initial forever begin
      @(negedge clk);
      if (armed) begin
        check($sformatf("cfg%0d a", g), a, e_a);
        check($sformatf("cfg%0d y", g), y, e_y);
        check($sformatf("cfg%0d valid", g), valid, e_valid);
        check($sformatf("cfg%0d table", g), tt, e_tt);
        check($sformatf("cfg%0d busy", g), busy, e_busy);
        check($sformatf("cfg%0d done", g), done, e_done);
      end
    end

    task automatic run_sweep(input int m, output int nv);
      nv = 0;
      mode = 3'(m);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mode = 3'($urandom);
      for (int i = 0; i < TW * GH + 4; i++) begin
        @(negedge clk);
        start = 1'b0;
        if (valid) nv++;
        if (done) break;
        start = (i == 1) || (i == 2);
        mode = 3'($urandom);
      end
      check($sformatf("cfg%0d sweep done", g), done, 1);
      check($sformatf("cfg%0d valid count", g), nv, TW);
    endtask

    initial begin
      int nv;
      longint exp_tt;
      exp_tt = CFG_TT[g];
      rst = 1'b1; start = 1'b0; mode = 3'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check($sformatf("cfg%0d reset busy", g), busy, 0);
      check($sformatf("cfg%0d reset table", g), tt, 0);

      run_sweep(CFG_MODE[g], nv);
      check($sformatf("cfg%0d directed table", g), tt, exp_tt);

      run_sweep(0, nv);
      check($sformatf("cfg%0d and table", g), tt, longint'(1) << (TW - 1));

      mode = 3'(CFG_MODE[g]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (GH + 4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check($sformatf("cfg%0d rst a", g), a, 0);
      check($sformatf("cfg%0d rst y", g), y, 0);
      check($sformatf("cfg%0d rst valid", g), valid, 0);
      check($sformatf("cfg%0d rst table", g), tt, 0);
      check($sformatf("cfg%0d rst busy", g), busy, 0);
      check($sformatf("cfg%0d rst done", g), done, 0);

      run_sweep(CFG_MODE[g], nv);
      check($sformatf("cfg%0d after rst table", g), tt, exp_tt);

      mode = 3'($urandom);
      start = 1'b1;
      repeat (2 * TW * GH + 3) @(negedge clk);
      start = 1'b0;
      repeat (TW * GH + 2) @(negedge clk);

      repeat (400) begin
        @(negedge clk);
        start = ($urandom % 6) == 0;
        mode = 3'($urandom);
        rst = ($urandom % 80) == 0;
      end
      start = 1'b0;
      rst = 1'b0;
      repeat (TW * GH + 2) @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (cfg[0].fin && cfg[1].fin && cfg[2].fin) break;
    end
    check("all configs finished", {cfg[0].fin, cfg[1].fin, cfg[2].fin}, 3'b111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
